l1b_yanitlayici: RTL and testbench

L1B_YANITLAYICI -- requirements
Module: l1b_yanitlayici

---
 rtl/l1b_yanitlayici_pkg.sv | 20 ++
 rtl/l1b_yanitlayici_fifo.sv | 59 +++++
 rtl/l1b_yanitlayici.sv | 157 +++++++++++++++
 tb/tb_l1b_yanitlayici.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1b_yanitlayici_pkg.sv
// Shared constants and helpers for the L1 instruction fetch responder.
//   PS_BIT / VERI_BIT : fetch address and instruction block widths
//   HIGH / LOW        : single-bit logic levels
//   kelime_hizala()   : clears the byte offset of a fetch address
package l1b_yanitlayici_pkg;

  localparam int unsigned PS_BIT   = 32;
  localparam int unsigned VERI_BIT = 32;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [PS_BIT-1:0] HIZA_MASKE = PS_BIT'(32'hFFFF_FFFC);

  // Word-align a fetch address
  function automatic logic [PS_BIT-1:0] kelime_hizala(input logic [PS_BIT-1:0] ps);
    return ps & HIZA_MASKE;
  endfunction

endpackage

// File: rtl/l1b_yanitlayici_fifo.sv
// In-order response buffer between memory and the second fetch stage.
//   clk_i, rstn_i     : clock, async active-low reset
//   yaz_i, yaz_veri_i : enqueue strobe and data
//   oku_i             : dequeue strobe (ignored when empty)
//   oku_veri_o        : head entry, driven straight from storage flops
//   dolu_o, bos_o     : full / empty flags
module yanit_fifo #(
  parameter int unsigned DERINLIK = 4,
  parameter int unsigned VERI_BIT = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                yaz_i,
  input  logic [VERI_BIT-1:0] yaz_veri_i,
  input  logic                oku_i,
  output logic [VERI_BIT-1:0] oku_veri_o,
  output logic                dolu_o,
  output logic                bos_o
);

  localparam int unsigned AW = $clog2(DERINLIK);

  logic [AW:0]         r_yaz_ptr;
  logic [AW:0]         r_oku_ptr;
  logic [VERI_BIT-1:0] r_bellek [DERINLIK];
  logic                w_yaz;
  logic                w_oku;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  assign bos_o  = (r_yaz_ptr == r_oku_ptr);
  assign dolu_o = (r_yaz_ptr[AW] != r_oku_ptr[AW]) &&
                  (r_yaz_ptr[AW-1:0] == r_oku_ptr[AW-1:0]);

  // Full plus dequeue frees the slot being written this cycle
  assign w_oku = oku_i && !bos_o;
  assign w_yaz = yaz_i && (!dolu_o || w_oku);

  assign oku_veri_o = r_bellek[r_oku_ptr[AW-1:0]];

  // Pointer and storage update
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_yaz_ptr <= '0;
      r_oku_ptr <= '0;
      for (int i = 0; i < int'(DERINLIK); i++) begin
        r_bellek[i] <= '0;
      end
    end else begin
      if (w_yaz) begin
        r_bellek[r_yaz_ptr[AW-1:0]] <= yaz_veri_i;
        r_yaz_ptr                   <= r_yaz_ptr + (AW+1)'(1);
      end
      if (w_oku) begin
        r_oku_ptr <= r_oku_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/l1b_yanitlayici.sv
// L1 instruction fetch responder: accepts fetch addresses from the first
// fetch stage, issues word-aligned memory reads, buffers the in-order memory
// data and returns one instruction block per accepted request.
//   clk_i, rstn_i                    : clock, async active-low reset
//   g1_istek_*                       : fetch request (address, valid, ready)
//   g2_buyruk_*                      : instruction block to the second stage
//   bellek_adres_o / bellek_istek_*  : memory read request
//   bellek_veri_i / bellek_yanit_*   : memory read data, in order, no backpressure
//   hata_o                           : sticky protocol-error flag
module l1b_yanitlayici
  import l1b_yanitlayici_pkg::*;
#(
  parameter int unsigned YANIT_DERINLIK      = 4,
  parameter int unsigned BELLEK_GECIKME_MAKS = 0
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [PS_BIT-1:0]   g1_istek_ps_i,
  input  logic                g1_istek_gecerli_i,
  output logic                g1_istek_hazir_o,
  output logic [VERI_BIT-1:0] g2_buyruk_o,
  output logic                g2_buyruk_gecerli_o,
  input  logic                g2_buyruk_hazir_i,
  output logic [PS_BIT-1:0]   bellek_adres_o,
  output logic                bellek_istek_gecerli_o,
  input  logic                bellek_istek_hazir_i,
  input  logic [VERI_BIT-1:0] bellek_veri_i,
  input  logic                bellek_yanit_gecerli_i,
  output logic                hata_o
);

  localparam int unsigned          KREDI_BIT  = $clog2(YANIT_DERINLIK) + 1;
  localparam logic [KREDI_BIT-1:0] KREDI_MAKS = KREDI_BIT'(YANIT_DERINLIK);

  logic [KREDI_BIT-1:0] r_kredi;
  logic [KREDI_BIT-1:0] r_bekleyen;
  logic [PS_BIT-1:0]    r_adres;
  logic                 r_istek_gecerli;
  logic                 r_hata;

  logic w_kabul;
  logic w_bellek_el;
  logic w_tuketim;
  logic w_sahte;
  logic w_yaz;
  logic w_fifo_bos;
  logic w_fifo_dolu;
  logic w_fifo_tasma;
  logic w_kredi_hata;
  logic w_zaman_asimi;

  // Credit bounds everything in flight, so the buffer can always absorb the data
  assign g1_istek_hazir_o = rstn_i && (r_kredi < KREDI_MAKS) &&
                            (!r_istek_gecerli || bellek_istek_hazir_i);

  assign w_kabul     = g1_istek_gecerli_i && g1_istek_hazir_o;
  assign w_bellek_el = r_istek_gecerli && bellek_istek_hazir_i;
  assign w_tuketim   = !w_fifo_bos && g2_buyruk_hazir_i;

  // A beat with no read outstanding is dropped and flagged
  assign w_sahte = bellek_yanit_gecerli_i && (r_bekleyen == '0);
  assign w_yaz   = bellek_yanit_gecerli_i && !w_sahte;

  assign w_fifo_tasma = w_yaz && w_fifo_dolu && !w_tuketim;
  assign w_kredi_hata = (w_kabul && !w_tuketim && (r_kredi == KREDI_MAKS)) ||
                        (w_tuketim && !w_kabul && (r_kredi == '0));

  assign bellek_adres_o         = r_adres;
  assign bellek_istek_gecerli_o = r_istek_gecerli;
  assign g2_buyruk_gecerli_o    = !w_fifo_bos;
  assign hata_o                 = r_hata;

  // Memory request register; reloads back-to-back on accept during a handshake
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_adres         <= '0;
      r_istek_gecerli <= LOW;
    end else if (w_kabul) begin
      r_adres         <= kelime_hizala(g1_istek_ps_i);
      r_istek_gecerli <= HIGH;
    end else if (w_bellek_el) begin
      r_istek_gecerli <= LOW;
    end
  end

  // Credit: accepted requests not yet consumed by the second stage
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_kredi <= '0;
    end else if (!w_kredi_hata) begin
      if (w_kabul && !w_tuketim) begin
        r_kredi <= r_kredi + KREDI_BIT'(1);
      end else if (w_tuketim && !w_kabul) begin
        r_kredi <= r_kredi - KREDI_BIT'(1);
      end
    end
  end

  // Memory reads handed over but not yet answered
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bekleyen <= '0;
    end else if (w_bellek_el && !w_yaz) begin
      r_bekleyen <= r_bekleyen + KREDI_BIT'(1);
    end else if (w_yaz && !w_bellek_el) begin
      r_bekleyen <= r_bekleyen - KREDI_BIT'(1);
    end
  end

  // Optional watchdog on memory response latency
  if (BELLEK_GECIKME_MAKS > 0) begin : g_zaman
    localparam int unsigned          SAYAC_BIT = $clog2(BELLEK_GECIKME_MAKS + 1);
    localparam logic [SAYAC_BIT-1:0] SINIR     = SAYAC_BIT'(BELLEK_GECIKME_MAKS);

    logic [SAYAC_BIT-1:0] r_bekleme;

    // Cycles waited since the last beat while reads are outstanding
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_bekleme <= '0;
      end else if ((r_bekleyen == '0) || bellek_yanit_gecerli_i) begin
        r_bekleme <= '0;
      end else if (r_bekleme != SINIR) begin
        r_bekleme <= r_bekleme + SAYAC_BIT'(1);
      end
    end

    assign w_zaman_asimi = (r_bekleyen != '0) && !bellek_yanit_gecerli_i &&
                           (r_bekleme == SINIR);
  end else begin : g_zaman_yok
    assign w_zaman_asimi = LOW;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hata <= LOW;
    end else if (w_sahte || w_kredi_hata || w_fifo_tasma || w_zaman_asimi) begin
      r_hata <= HIGH;
    end
  end

  yanit_fifo #(
    .DERINLIK (YANIT_DERINLIK),
    .VERI_BIT (VERI_BIT)
  ) u_yanit_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .yaz_i      (w_yaz),
    .yaz_veri_i (bellek_veri_i),
    .oku_i      (w_tuketim),
    .oku_veri_o (g2_buyruk_o),
    .dolu_o     (w_fifo_dolu),
    .bos_o      (w_fifo_bos)
  );

endmodule

// File: tb/tb_l1b_yanitlayici.sv
// Scoreboard bench for l1b_yanitlayici: a memory model answers reads in
// order, accepted fetches push their expected block, and a monitor compares
// every consumed block against that queue.
module tb_l1b_yanitlayici;
  import l1b_yanitlayici_pkg::*;

  localparam int D = 4;

  logic                clk = 1'b0;
  logic                rstn;
  logic [PS_BIT-1:0]   g1_ps;
  logic                g1_gec;
  logic                g1_haz;
  logic [VERI_BIT-1:0] g2_buy;
  logic                g2_gec;
  logic                g2_haz;
  logic [PS_BIT-1:0]   bel_adr;
  logic                bel_ig;
  logic                bel_haz;
  logic [VERI_BIT-1:0] bel_veri;
  logic                bel_yg;
  logic                hata;

  int checks = 0;
  int errors = 0;
  int dongu  = 0;

  // Scoreboard state
  logic [31:0] q_adres[$];
  logic [31:0] q_blok[$];
  logic [31:0] q_bel[$];
  int          q_bel_t[$];
  int          kredi_m   = 0;
  int          kabul_say = 0;
  int          tuketilen = 0;

  // Memory model controls (written by main only in the post-sample window)
  int bel_mod     = 0;   // 0 ready, 1 stalled, 2 random
  int gecikme     = 2;
  int yanit_yuzde = 100;
  int sahte_iste  = 0;

  l1b_yanitlayici #(
    .YANIT_DERINLIK      (D),
    .BELLEK_GECIKME_MAKS (0)
  ) dut (
    .clk_i                  (clk),
    .rstn_i                 (rstn),
    .g1_istek_ps_i          (g1_ps),
    .g1_istek_gecerli_i     (g1_gec),
    .g1_istek_hazir_o       (g1_haz),
    .g2_buyruk_o            (g2_buy),
    .g2_buyruk_gecerli_o    (g2_gec),
    .g2_buyruk_hazir_i      (g2_haz),
    .bellek_adres_o         (bel_adr),
    .bellek_istek_gecerli_o (bel_ig),
    .bellek_istek_hazir_i   (bel_haz),
    .bellek_veri_i          (bel_veri),
    .bellek_yanit_gecerli_i (bel_yg),
    .hata_o                 (hata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) dongu <= dongu + 1;

  // Memory contents: a fixed scramble of the word address
  function automatic logic [31:0] veri_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    checks++;
    if (gercek !== beklenen) begin
      errors++;
      $display("FAIL %s gercek=%h beklenen=%h t=%0t", ad, gercek, beklenen, $time);
    end
  endtask

  task automatic cevrim(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #4;
    end
  endtask

  // Stimulus side: every accepted fetch pushes its expected address and block
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rstn) begin
        q_adres.delete();
        q_blok.delete();
        kredi_m = 0;
      end else begin
        if (kredi_m == D) kontrol("kredi_dolu_hazir", 32'(g1_haz), 32'd0);
        if (g1_gec && g1_haz) begin
          q_adres.push_back(g1_ps & 32'hFFFF_FFFC);
          q_blok.push_back(veri_f(g1_ps & 32'hFFFF_FFFC));
          kredi_m++;
          kabul_say++;
        end
        if (g2_gec && g2_haz) kredi_m--;
      end
    end
  end

  // Memory model: in-order responses after at least 'gecikme' cycles
  initial begin
    int          sahte_yapildi = 0;
    bit          onceki_bekle  = 1'b0;
    logic [31:0] onceki_adr    = '0;
    bel_haz  = 1'b0;
    bel_yg   = 1'b0;
    bel_veri = '0;
    forever begin
      @(negedge clk);
      bel_yg   = 1'b0;
      bel_veri = '0;
      bel_haz  = (bel_mod == 0) ? 1'b1 : (bel_mod == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (sahte_iste != sahte_yapildi) begin
        sahte_yapildi = sahte_iste;
        bel_yg   = 1'b1;
        bel_veri = 32'h1234_5678;
      end else if (rstn && q_bel.size() > 0 && (q_bel_t[0] + gecikme <= dongu) &&
                   ($urandom_range(0, 99) < yanit_yuzde)) begin
        bel_yg   = 1'b1;
        bel_veri = veri_f(q_bel.pop_front());
        void'(q_bel_t.pop_front());
      end
      #4;
      if (!rstn) begin
        q_bel.delete();
        q_bel_t.delete();
        onceki_bekle = 1'b0;
      end else begin
        if (onceki_bekle) begin
          kontrol("adres_sabit_gecerli", 32'(bel_ig), 32'd1);
          kontrol("adres_sabit", bel_adr, onceki_adr);
        end
        if (bel_ig && bel_haz) begin
          kontrol("bellek_istek_bekleniyor", 32'(q_adres.size() != 0), 32'd1);
          if (q_adres.size() != 0) kontrol("bellek_adres", bel_adr, q_adres.pop_front());
          q_bel.push_back(bel_adr);
          q_bel_t.push_back(dongu);
        end
        onceki_bekle = bel_ig && !bel_haz;
        onceki_adr   = bel_adr;
      end
    end
  end

  // Monitor: every consumed block must be the oldest expected one
  initial begin
    bit          onceki_bekle = 1'b0;
    logic [31:0] onceki_buy   = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rstn) begin
        onceki_bekle = 1'b0;
      end else begin
        if (onceki_bekle) begin
          kontrol("g2_sabit_gecerli", 32'(g2_gec), 32'd1);
          kontrol("g2_sabit", g2_buy, onceki_buy);
        end
        if (g2_gec && g2_haz) begin
          kontrol("blok_bekleniyor", 32'(q_blok.size() != 0), 32'd1);
          if (q_blok.size() != 0) kontrol("blok_sira", g2_buy, q_blok.pop_front());
          tuketilen++;
        end
        onceki_bekle = g2_gec && !g2_haz;
        onceki_buy   = g2_buy;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL zaman_asimi bench did not finish");
    $fatal(1);
  end

  initial begin
    int kabul_baz;
    int tuk_baz;
    rstn   = 1'b0;
    g1_gec = 1'b0;
    g1_ps  = '0;
    g2_haz = 1'b0;

    #2;
    kontrol("rst_g1_hazir", 32'(g1_haz), 32'd0);
    kontrol("rst_bel_gecerli", 32'(bel_ig), 32'd0);
    kontrol("rst_g2_gecerli", 32'(g2_gec), 32'd0);
    kontrol("rst_hata", 32'(hata), 32'd0);
    kontrol("rst_adres", bel_adr, 32'd0);
    kontrol("rst_buyruk", g2_buy, 32'd0);

    // Single fetch, accepted on the first edge after release
    @(negedge clk);
    rstn   = 1'b1;
    g1_gec = 1'b1;
    g1_ps  = 32'h0000_1006;
    #4;
    kontrol("ilk_kabul_hazir", 32'(g1_haz), 32'd1);
    @(negedge clk);
    g1_gec = 1'b0;
    #4;
    kontrol("istek_gecerli", 32'(bel_ig), 32'd1);
    kontrol("adres_hizali", bel_adr, 32'h0000_1004);
    @(negedge clk); #4;
    kontrol("istek_tamam", 32'(bel_ig), 32'd0);
    kontrol("g2_erken", 32'(g2_gec), 32'd0);
    @(negedge clk); #4;
    kontrol("bypass_yok", 32'(g2_gec), 32'd0);
    @(negedge clk); #4;
    kontrol("g2_gecerli", 32'(g2_gec), 32'd1);
    kontrol("g2_veri", g2_buy, veri_f(32'h0000_1004));
    @(negedge clk);
    g2_haz = 1'b1;
    #4;
    @(negedge clk);
    g2_haz = 1'b0;
    #4;
    kontrol("g2_tuketildi", 32'(g2_gec), 32'd0);
    gecikme = 1;

    // Credit exhaustion with the second stage stalled
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g1_gec = 1'b1;
      g1_ps  = 32'h200 + 32'(4 * i);
      #4;
      kontrol("kredi_kabul", 32'(g1_haz), 32'd1);
    end
    @(negedge clk);
    g1_ps = 32'h210;
    #4;
    kontrol("besinci_red", 32'(g1_haz), 32'd0);
    g1_gec = 1'b0;
    cevrim(5);
    kontrol("fifo_dolu_gecerli", 32'(g2_gec), 32'd1);
    kontrol("fifo_dolu_hazir", 32'(g1_haz), 32'd0);
    @(negedge clk);
    g2_haz = 1'b1;
    #4;
    kontrol("tuketim_ayni_cevrim", 32'(g1_haz), 32'd0);
    @(negedge clk);
    g1_gec = 1'b1;
    g1_ps  = 32'h220;
    #4;
    kontrol("tuketim_sonrasi_hazir", 32'(g1_haz), 32'd1);
    @(negedge clk);
    g1_ps  = 32'h224;
    g2_haz = 1'b0;
    #4;
    kontrol("kredi3_korundu", 32'(g1_haz), 32'd1);
    @(negedge clk);
    g1_ps = 32'h228;
    #4;
    kontrol("kredi_tekrar_dolu", 32'(g1_haz), 32'd0);
    @(negedge clk);
    g1_gec = 1'b0;
    g2_haz = 1'b1;
    cevrim(12);
    kontrol("bosaltma_kuyruk", 32'(q_blok.size()), 32'd0);
    kontrol("bosaltma_g2", 32'(g2_gec), 32'd0);
    bel_mod = 1;

    // Memory backpressure, then back-to-back issue
    @(negedge clk);
    g1_gec = 1'b1;
    g1_ps  = 32'h100;
    #4;
    kontrol("bp_kabul", 32'(g1_haz), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g1_ps = 32'h104;
      #4;
      kontrol("bp_hazir", 32'(g1_haz), 32'd0);
      kontrol("bp_adres", bel_adr, 32'h100);
    end
    bel_mod = 0;
    @(negedge clk); #4;
    kontrol("bp_serbest_hazir", 32'(g1_haz), 32'd1);
    kontrol("b2b_0", bel_adr, 32'h100);
    @(negedge clk);
    g1_ps = 32'h108;
    #4;
    kontrol("b2b_1", bel_adr, 32'h104);
    kontrol("b2b_1_gecerli", 32'(bel_ig), 32'd1);
    @(negedge clk);
    g1_gec = 1'b0;
    #4;
    kontrol("b2b_2", bel_adr, 32'h108);
    kontrol("b2b_2_gecerli", 32'(bel_ig), 32'd1);
    cevrim(10);
    kontrol("bp_bosaltma", 32'(q_blok.size()), 32'd0);
    bel_mod     = 2;
    yanit_yuzde = 60;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      g1_gec = ($urandom_range(0, 99) < 60);
      g1_ps  = $urandom;
      g2_haz = ($urandom_range(0, 99) < 70);
      #4;
    end
    bel_mod     = 0;
    yanit_yuzde = 100;
    @(negedge clk);
    g1_gec = 1'b0;
    g2_haz = 1'b1;
    cevrim(30);
    kontrol("rastgele_bosaltma", 32'(q_blok.size()), 32'd0);
    kontrol("rastgele_hata_yok", 32'(hata), 32'd0);

    // Spurious memory beat with nothing outstanding
    sahte_iste++;
    cevrim(2);
    kontrol("sahte_hata", 32'(hata), 32'd1);
    kontrol("sahte_fifo_bos", 32'(g2_gec), 32'd0);
    cevrim(3);
    kontrol("hata_yapiskan", 32'(hata), 32'd1);

    // Three blocks buffered, then asynchronous reset mid-cycle
    @(negedge clk);
    g2_haz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      g1_gec = 1'b1;
      g1_ps  = $urandom;
      #4;
      kontrol("tampon_kabul", 32'(g1_haz), 32'd1);
      @(negedge clk);
    end
    g1_gec = 1'b0;
    cevrim(6);
    kontrol("uc_blok_gecerli", 32'(g2_gec), 32'd1);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    kontrol("async_g2_gecerli", 32'(g2_gec), 32'd0);
    kontrol("async_bel_gecerli", 32'(bel_ig), 32'd0);
    kontrol("async_g1_hazir", 32'(g1_haz), 32'd0);
    kontrol("async_hata", 32'(hata), 32'd0);
    kontrol("async_buyruk", g2_buy, 32'd0);
    bel_mod     = 2;
    yanit_yuzde = 60;
    cevrim(2);
    @(negedge clk);
    rstn = 1'b1;
    #4;
    kontrol("yeniden_hazir", 32'(g1_haz), 32'd1);
    kabul_baz = kabul_say;
    tuk_baz   = tuketilen;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g1_gec = ((kabul_say - kabul_baz) < 20) && ($urandom_range(0, 99) < 70);
      g1_ps  = $urandom;
      g2_haz = ($urandom_range(0, 99) < 60);
      #4;
    end
    bel_mod     = 0;
    yanit_yuzde = 100;
    @(negedge clk);
    g1_gec = 1'b0;
    g2_haz = 1'b1;
    cevrim(20);
    kontrol("yirmi_kabul", 32'(kabul_say - kabul_baz), 32'd20);
    kontrol("yirmi_donus", 32'(tuketilen - tuk_baz), 32'd20);
    kontrol("son_kuyruk", 32'(q_blok.size()), 32'd0);
    kontrol("son_hata", 32'(hata), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
